// File: rtl/result_buffer.sv
// Result RAM: random-access writes from the GEMM datapath while idle, then a
// streamed readout of words 0..len-1 over valid/ready/last; 2-cycle first-beat latency, 1 beat/cycle.
module result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SIZE  = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  conv_en,
  input  logic                  res_wr,
  input  logic [ADDR_SIZE-1:0]  res_addr,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  input  logic                  conv_done,
  input  logic [ADDR_SIZE:0]    res_len,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  r_last,
  output logic                  tx_done,
  output logic                  wr_err
);

  localparam int CW = ADDR_SIZE + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         len, rd_addr, beat_cnt, len_clip;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;
  logic                  start, issue, pop, ram_we;

  assign len_clip  = (res_len > CW'(DEPTH)) ? CW'(DEPTH) : res_len;
  assign start     = (state == IDLE) && conv_done && enable;
  assign ram_we    = (state == IDLE) && res_wr;
  // The synchronous RAM read lands straight in the FIFO slot at the issuing
  // edge, so no read is still outstanding when the next issue is decided.
  assign issue     = (state == SEND) && (rd_addr < len) && (fifo_cnt < 2'd2);
  assign res_ready = (state == IDLE);
  assign r_valid   = (fifo_cnt != 2'd0);
  assign r_data    = fifo[rd_ptr];
  assign r_last    = r_valid && (beat_cnt == len - CW'(1));
  assign pop       = r_valid && r_ready;

  always_ff @(posedge clk) begin
    if (ram_we) mem[res_addr] <= res_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && (len_clip != '0)) state_nxt = SEND;
      SEND: if (pop && r_last)             state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len      <= '0;
      rd_addr  <= '0;
      beat_cnt <= '0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      tx_done  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (start) begin
        len      <= len_clip;
        rd_addr  <= '0;
        beat_cnt <= '0;
        if (len_clip == '0) tx_done <= 1'b1;
      end
      if (issue) begin
        fifo[wr_ptr] <= mem[rd_addr[ADDR_SIZE-1:0]];
        wr_ptr       <= ~wr_ptr;
        rd_addr      <= rd_addr + CW'(1);
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        beat_cnt <= beat_cnt + CW'(1);
        if (r_last) tx_done <= 1'b1;
      end
      fifo_cnt <= fifo_cnt + 2'(issue) - 2'(pop);
      // An error in the same cycle as conv_en takes priority over the clear.
      if (res_wr && !res_ready) wr_err <= 1'b1;
      else if (conv_en)         wr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer: cycle table for the basic stream, then
// hand-written sequences for stalls, full depth, errors and mid-stream reset.
module tb_result_buffer;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable, conv_en, res_wr, conv_done, r_ready;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic [AW:0]   res_len;
  logic          res_ready, r_valid, r_last, tx_done, wr_err;
  logic [DW-1:0] r_data;

  int n_cmp = 0;
  int n_err = 0;

  result_buffer #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .DEPTH(1024)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .conv_en(conv_en),
    .res_wr(res_wr), .res_addr(res_addr), .res_data(res_data),
    .res_ready(res_ready), .conv_done(conv_done), .res_len(res_len),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .r_last(r_last), .tx_done(tx_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          cd;
    logic [AW:0]   len;
    logic          rdy;
    logic          vld;
    logic [DW-1:0] dat;
    logic          last;
    logic          txd;
    logic          rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic cd, logic [AW:0] len, logic rdy,
                              logic vld, logic [DW-1:0] dat, logic last,
                              logic txd, logic rr);
    vec_t v;
    v.en = en; v.cd = cd; v.len = len; v.rdy = rdy;
    v.vld = vld; v.dat = dat; v.last = last; v.txd = txd; v.rr = rr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      res_wr = 1'b1; res_addr = AW'(i); res_data = base + DW'(i);
      tick();
    end
    res_wr = 1'b0;
  endtask

  task automatic start(input int len);
    conv_done = 1'b1; res_len = (AW+1)'(len);
    tick();
    conv_done = 1'b0; res_len = '0;
  endtask

  // Drives r_ready from a repeating 4-cycle pattern and collects beats until tx_done.
  task automatic stream_check(input int n, input logic [DW-1:0] base, input logic [3:0] pat,
                              input int budget, input string tag);
    int            got = 0;
    bit            done = 0;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    for (int c = 0; c < budget && !done; c++) begin
      r_ready = pat[c % 4];
      if (tx_done) begin
        done = 1;
        check({tag, " valid_at_done"}, 64'(r_valid), 64'd0);
      end else begin
        if (r_valid && pv && !pr) begin
          check({tag, " hold_data"}, 64'(r_data), 64'(pd));
          check({tag, " hold_last"}, 64'(r_last), 64'(pl));
        end
        if (r_valid && r_ready) begin
          check({tag, " data"}, 64'(r_data), 64'(base + DW'(got)));
          check({tag, " last"}, 64'(r_last), 64'(got == n - 1));
          got++;
        end
        pv = r_valid; pr = r_ready; pd = r_data; pl = r_last;
        tick();
      end
    end
    check({tag, " beats"}, 64'(got), 64'(n));
    check({tag, " tx_done_seen"}, 64'(done), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; enable = 1'b1; conv_en = 1'b0; res_wr = 1'b0; conv_done = 1'b0;
    r_ready = 1'b0; res_addr = '0; res_data = '0; res_len = '0;
    #1;
    check("rst r_valid",   64'(r_valid),   64'd0);
    check("rst r_last",    64'(r_last),    64'd0);
    check("rst r_data",    64'(r_data),    64'd0);
    check("rst tx_done",   64'(tx_done),   64'd0);
    check("rst wr_err",    64'(wr_err),    64'd0);
    check("rst res_ready", 64'(res_ready), 64'd1);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    tick();

    // 8-word stream at full rate, then len=0, then conv_done with enable low.
    vecs.push_back(mk(1, 1, 11'd8, 1, 0, '0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 11'd0, 1, 0, '0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 11'd0, 1, 1, 32'hA000 + 32'(i), (i == 7), 0, 0));
    vecs.push_back(mk(1, 0, 11'd0, 1, 0, '0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 11'd0, 1, 0, '0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 11'd0, 1, 0, '0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 11'd0, 1, 0, '0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 11'd0, 1, 0, '0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 11'd4, 1, 0, '0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 11'd0, 1, 0, '0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 11'd0, 1, 0, '0, 0, 0, 1));

    fill(8, 32'hA000);
    foreach (vecs[k]) begin
      enable = vecs[k].en; conv_done = vecs[k].cd; res_len = vecs[k].len; r_ready = vecs[k].rdy;
      check($sformatf("vec%0d r_valid", k), 64'(r_valid), 64'(vecs[k].vld));
      if (vecs[k].vld)
        check($sformatf("vec%0d r_data", k), 64'(r_data), 64'(vecs[k].dat));
      check($sformatf("vec%0d r_last", k),    64'(r_last),    64'(vecs[k].last));
      check($sformatf("vec%0d tx_done", k),   64'(tx_done),   64'(vecs[k].txd));
      check($sformatf("vec%0d res_ready", k), 64'(res_ready), 64'(vecs[k].rr));
      tick();
    end
    conv_done = 1'b0; res_len = '0; enable = 1'b1;

    // Backpressure with r_ready pattern 1,0,0,1.
    start(8);
    stream_check(8, 32'hA000, 4'b1001, 100, "stall");

    // Full depth with an oversized length request.
    fill(1024, 32'h5000_0000);
    start(1029);
    stream_check(1024, 32'h5000_0000, 4'b1111, 1100, "depth");

    // Writes and conv_done during SEND are rejected; error beats a same-cycle conv_en.
    fill(4, 32'hC000);
    r_ready = 1'b0;
    start(4);
    res_wr = 1'b1; res_addr = '0; res_data = 32'hDEAD; conv_done = 1'b1; res_len = 11'd8;
    tick();
    conv_done = 1'b0; res_len = '0;
    check("err set", 64'(wr_err), 64'd1);
    conv_en = 1'b1;
    tick();
    res_wr = 1'b0; conv_en = 1'b0;
    check("err beats conv_en", 64'(wr_err), 64'd1);
    stream_check(4, 32'hC000, 4'b1111, 50, "err");
    check("err sticky", 64'(wr_err), 64'd1);
    conv_en = 1'b1;
    tick();
    conv_en = 1'b0;
    check("err cleared", 64'(wr_err), 64'd0);

    // Reset while beat 3 of 8 is presented.
    fill(8, 32'hA000);
    r_ready = 1'b1;
    start(8);
    repeat (4) tick();
    check("mid beat3 data", 64'(r_data), 64'h0000_A003);
    rstn = 1'b0;
    #1;
    check("mid rst r_valid",   64'(r_valid),   64'd0);
    check("mid rst res_ready", 64'(res_ready), 64'd1);
    check("mid rst r_last",    64'(r_last),    64'd0);
    check("mid rst tx_done",   64'(tx_done),   64'd0);
    #2 rstn = 1'b1;
    tick();
    // Second word is written in the same cycle as conv_done and must still be sent.
    fill(1, 32'hE000);
    res_wr = 1'b1; res_addr = 10'd1; res_data = 32'hE001;
    start(2);
    res_wr = 1'b0;
    stream_check(2, 32'hE000, 4'b1111, 20, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
Name: result_buffer

Overview:
- Output-side counterpart of the weight buffer. The GEMM datapath writes results into an internal single-port RAM through a random-access port.
- After a conv_done pulse, the block streams result words 0..len-1 to the DMA over a valid/ready/last interface at full throughput.
- It sits between the GEMM accumulator writeback and the DMA read channel (ram --> dma).

Parameters:
- DATA_WIDTH, 32, width of one result word.
- ADDR_SIZE, 10, RAM address width.
- DEPTH, 1024, RAM words; must equal 2**ADDR_SIZE.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  block enable from the AXI register bank; when low, conv_done is ignored.
- conv_en  in  1  compute start pulse; clears the sticky error flag.
- res_wr  in  1  internal write strobe.
- res_addr  in  ADDR_SIZE  internal write address.
- res_data  in  DATA_WIDTH  internal write data.
- res_ready  out  1  high when internal writes are accepted (state IDLE).
- conv_done  in  1  pulse: results complete, start transmit.
- res_len  in  ADDR_SIZE+1  number of words to send; sampled on conv_done.
- r_data  out  DATA_WIDTH  DMA stream data.
- r_valid  out  1  DMA stream valid.
- r_ready  in  1  DMA stream ready.
- r_last  out  1  marks the final beat.
- tx_done  out  1  one-cycle pulse after the final beat is accepted.
- wr_err  out  1  sticky: res_wr asserted while res_ready was low.

Behaviour:
- Reset values: r_valid=0, r_last=0, r_data=0, tx_done=0, wr_err=0, res_ready=1, state IDLE, all counters 0.
- RAM: single port, synchronous read, 1-cycle latency. In IDLE the port is owned by the write path. In SEND it is owned by the read path.
- IDLE:
  - res_wr writes res_data to res_addr in the same cycle.
  - On conv_done && enable: latch len = min(res_len, DEPTH).
  - If len==0: pulse tx_done the next cycle and stay in IDLE.
  - Otherwise go to SEND, with rd_addr=0, beat_cnt=0, res_ready=0.
- SEND, read side:
  - 2-entry output FIFO (skid) feeds r_data/r_valid.
  - Issue a RAM read at rd_addr when rd_addr<len and (fifo_count + reads_in_flight) < 2. Then increment rd_addr.
  - Read data enters the FIFO one cycle after issue.
- SEND, output side:
  - r_valid = FIFO non-empty; r_data = FIFO head.
  - While r_valid && !r_ready, r_data and r_last hold stable.
  - A beat transfers when r_valid && r_ready; beat_cnt then increments.
  - r_last = r_valid && (beat_cnt == len-1).
- Latency and throughput:
  - First r_valid rises 2 cycles after the conv_done cycle.
  - With r_ready held high, one beat per cycle is sustained, with no bubbles after the first.
- Completion:
  - When the beat with r_last transfers: go to IDLE next cycle, pulse tx_done for 1 cycle, res_ready=1.
  - FIFO and in-flight reads are empty at that point by construction.
- Simultaneous events:
  - res_wr in the same cycle as conv_done (in IDLE): the write completes, then transmit starts. That word is sent.
  - conv_done while in SEND: ignored.
  - res_wr while in SEND: write dropped, wr_err set.
  - conv_en in the same cycle as an error event: the error wins.
  - conv_en has no other effect.
- len==DEPTH: rd_addr counts to DEPTH. It is held in an ADDR_SIZE+1 width counter, and the RAM address is its low bits.
- enable deasserted mid-SEND: the transfer completes normally.
- rstn asserted mid-operation: outputs return to reset values immediately and the partial stream is abandoned. RAM contents are undefined and not relied upon.

Test Plan:
- Write words 0..7 with value 0xA000+addr, conv_done with res_len=8, r_ready=1 -> 8 consecutive beats 0xA000..0xA007, first r_valid 2 cycles after conv_done, r_last on beat 7 only, tx_done 1 cycle after.
- Same fill, r_ready toggling 1,0,0,1,... -> no dropped or duplicated words, r_data stable while stalled, order 0xA000..0xA007, r_last on the last word.
- conv_done with res_len=0 -> r_valid never rises, tx_done pulses the next cycle, res_ready stays 1.
- Fill DEPTH words, res_len=DEPTH+5 -> exactly 1024 beats, r_last on beat 1023, address wrap-free.
- res_wr and conv_done during SEND with res_len=4 -> wr_err=1, stream still carries the original 4 words. A later conv_en clears wr_err.
- rstn low at beat 3 of 8 -> r_valid=0 immediately, res_ready=1. A new fill plus conv_done (res_len=2) streams 2 correct words.
